serial_ripple_subtractor: RTL and testbench

Bit-serial ripple-borrow subtractor. It computes `a - b - bin` one bit per clock, LSB first, and returns the difference, the borrow-out and a signed-overflow flag. It is the subtract-direction counterpart to the combinational ripple carry adder in the arithmetic library. The datapath is one full-subtractor cell reused across cycles, which trades latency for area.

---
 rtl/serial_ripple_subtractor_pkg.sv | 17 +
 rtl/serial_ripple_subtractor_if.sv | 25 ++
 rtl/serial_ripple_subtractor_full_subtractor.sv | 12 +
 rtl/serial_ripple_subtractor.sv | 131 +++++++++++++
 tb/tb_serial_ripple_subtractor.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared arithmetic package for the bit-serial subtractor.
// State encoding, default width and counter sizing helper.
package serial_ripple_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 4;

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_ripple_subtractor_if.sv
// Operand/result bundle of the bit-serial subtractor.
// The master drives operands and start, the slave returns results.
interface serial_ripple_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_ripple_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bi.
// Reused serially by the top level, one bit per clock.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor, LSB first.
// Computes a - b - bin over WIDTH cycles with one cell.
module serial_ripple_subtractor
  import serial_ripple_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clk,
  input logic rst,
  serial_ripple_subtractor_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic fs_d;
  logic fs_bo;

  full_subtractor u_fs (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (br_q),
    .d  (fs_d),
    .bo (fs_bo)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
          cnt_d   = '0;
          sh_d    = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        sh_d  = {fs_d, sh_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = fs_bo;
        cnt_d = cnt_q + 1'b1;
        // last bit: publish result on the same edge
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          diff_d  = {fs_d, sh_q[WIDTH-1:1]};
          bout_d  = fs_bo;
          ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ fs_d);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      sh_q    <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Scoreboard bench for the bit-serial subtractor, WIDTH = 4.
// Expected results come from a whole-word arithmetic model.
module tb_serial_ripple_subtractor;

  typedef struct {
    logic [3:0] diff;
    logic       bout;
    logic       ovf;
  } res_t;

  logic clk;
  logic rst;

  serial_ripple_subtractor_if #(.WIDTH(4)) bus ();

  serial_ripple_subtractor #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  res_t sb[$];
  res_t last_r;
  int   n_tests;
  int   n_fail;
  int   done_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [3:0] a, input logic [3:0] b,
                                 input logic bin);
    res_t r;
    logic [4:0] t;
    t = {1'b0, a} - {1'b0, b} - {4'b0, bin};
    r.diff = t[3:0];
    r.bout = t[4];
    r.ovf  = (a[3] ^ b[3]) & (a[3] ^ t[3]);
    return r;
  endfunction

  always @(negedge clk) begin
    if (bus.done) begin
      res_t e;
      done_cnt++;
      chk("busy_done_excl", {31'b0, bus.busy}, 32'd0);
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("diff", {28'b0, bus.diff}, {28'b0, e.diff});
        chk("bout", {31'b0, bus.bout}, {31'b0, e.bout});
        chk("ovf", {31'b0, bus.ovf}, {31'b0, e.ovf});
      end
    end
  end

  // call right after a negedge; returns on a negedge with the FSM idle
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic bin);
    res_t hold;
    hold = last_r;
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    sb.push_back(model(a, b, bin));
    last_r = model(a, b, bin);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = 4'($urandom);
    bus.b = 4'($urandom);
    bus.bin = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy", {31'b0, bus.busy}, 32'd1);
      chk("early_done", {31'b0, bus.done}, 32'd0);
      chk("hold_diff", {28'b0, bus.diff}, {28'b0, hold.diff});
    end
    @(negedge clk);
    chk("done_lat", {31'b0, bus.done}, 32'd1);
    chk("busy_off", {31'b0, bus.busy}, 32'd0);
    @(negedge clk);
    chk("done_pulse", {31'b0, bus.done}, 32'd0);
  endtask

  initial begin
    int n0;
    n_tests = 0;
    n_fail = 0;
    done_cnt = 0;
    last_r = '{4'h0, 1'b0, 1'b0};
    rst = 1'b1;
    bus.start = 1'b1;
    bus.a = 4'hF;
    bus.b = 4'h1;
    bus.bin = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_diff", {28'b0, bus.diff}, 32'd0);
    chk("rst_bout", {31'b0, bus.bout}, 32'd0);
    chk("rst_ovf", {31'b0, bus.ovf}, 32'd0);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", {31'b0, bus.busy}, 32'd0);

    run_op(4'b0110, 4'b1100, 1'b0);
    run_op(4'b1101, 4'b1001, 1'b1);
    run_op(4'b1000, 4'b0001, 1'b0);
    run_op(4'b1111, 4'b1111, 1'b1);

    // operand change and start pulse while running
    n0 = done_cnt;
    bus.start = 1'b1;
    bus.a = 4'h0;
    bus.b = 4'h1;
    bus.bin = 1'b0;
    sb.push_back(model(4'h0, 4'h1, 1'b0));
    last_r = model(4'h0, 4'h1, 1'b0);
    @(negedge clk);
    bus.a = 4'hA;
    bus.b = 4'h3;
    bus.bin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("one_done", 32'(done_cnt - n0), 32'd1);
    chk("robust_diff", {28'b0, bus.diff}, 32'hF);
    chk("robust_bout", {31'b0, bus.bout}, 32'd1);

    // reset in the second RUN cycle discards the operation
    n0 = done_cnt;
    bus.start = 1'b1;
    bus.a = 4'h0;
    bus.b = 4'h1;
    bus.bin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("mid_rst_diff", {28'b0, bus.diff}, 32'd0);
    chk("mid_rst_bout", {31'b0, bus.bout}, 32'd0);
    chk("mid_rst_ovf", {31'b0, bus.ovf}, 32'd0);
    rst = 1'b0;
    last_r = '{4'h0, 1'b0, 1'b0};
    repeat (8) @(negedge clk);
    chk("no_done", 32'(done_cnt - n0), 32'd0);

    run_op(4'h0, 4'h1, 1'b0);
    run_op(4'h0, 4'h0, 1'b1);
    run_op(4'h7, 4'h8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_op(4'($urandom), 4'($urandom), 1'($urandom));
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
